// File: rtl/vend_pkg.sv
// Shared types and constants for the vending purchase sequencer.
package vend_pkg;

    localparam int MONEY_W = 8;
    localparam int ITEM_W  = 2;

    // Default item prices in half-units (1-coin = 2, 10-coin = 20).
    localparam logic [MONEY_W-1:0] PRICE0_DEF = 8'd5;
    localparam logic [MONEY_W-1:0] PRICE1_DEF = 8'd6;
    localparam logic [MONEY_W-1:0] PRICE2_DEF = 8'd10;
    localparam logic [MONEY_W-1:0] PRICE3_DEF = 8'd30;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_ARM      = 3'd1,
        S_EVAL     = 3'd2,
        S_DISPENSE = 3'd3,
        S_CHANGE   = 3'd4,
        S_CLEAR    = 3'd5
    } state_t;

endpackage

// File: rtl/vend_controller_edge_rise.sv
// Registered rising-edge detector; the previous value updates every cycle.
module edge_rise (
    input  logic clk,
    input  logic rst,
    input  logic sig_i,
    output logic rise_o
);

    logic prev_q;

    // Remember last cycle's level so a held button produces a single edge.
    always_ff @(posedge clk) begin
        if (rst) prev_q <= 1'b0;
        else     prev_q <= sig_i;
    end

    assign rise_o = sig_i & ~prev_q;

endmodule

// File: rtl/vend_controller.sv
// Purchase sequencer: select/cancel handling, credit evaluation, dispense,
// change return and accumulator clear.
//
// state    | meaning
// IDLE     | waiting for a select or cancel edge; accumulator unlocked
// ARM      | accumulator locked, one cycle for a last coin to settle
// EVAL     | credit frozen; decide dispense, refund, reject or abort
// DISPENSE | dispense strobe held for DISP_CYCLES cycles
// CHANGE   | change_amt presented for CHG_CYCLES cycles
// CLEAR    | one-cycle clear pulse to the accumulator
module vend_controller
    import vend_pkg::*;
#(
    parameter logic [MONEY_W-1:0] PRICE0      = PRICE0_DEF,
    parameter logic [MONEY_W-1:0] PRICE1      = PRICE1_DEF,
    parameter logic [MONEY_W-1:0] PRICE2      = PRICE2_DEF,
    parameter logic [MONEY_W-1:0] PRICE3      = PRICE3_DEF,
    parameter int                 DISP_CYCLES = 4,
    parameter int                 CHG_CYCLES  = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [MONEY_W-1:0] moneyv,
    input  logic               sel_valid,
    input  logic [ITEM_W-1:0]  sel_item,
    input  logic               cancel,
    output logic               lock,
    output logic               macc_rst,
    output logic               dispense,
    output logic [ITEM_W-1:0]  dispense_item,
    output logic               change_valid,
    output logic [MONEY_W-1:0] change_amt,
    output logic               insufficient
);

    localparam int CNT_MAX = (DISP_CYCLES > CHG_CYCLES) ? DISP_CYCLES : CHG_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] DISP_LOAD = CNT_W'(DISP_CYCLES - 1);
    localparam logic [CNT_W-1:0] CHG_LOAD  = CNT_W'(CHG_CYCLES - 1);

    state_t             state_q, state_d;
    logic [ITEM_W-1:0]  item_q, item_d;
    logic [MONEY_W-1:0] price_q, price_d;
    logic [MONEY_W-1:0] change_q, change_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               refund_q, refund_d;
    logic               insuff_q, insuff_d;
    logic               sel_rise, cancel_rise;
    logic [MONEY_W-1:0] sel_price;

    edge_rise u_sel_edge (
        .clk    (clk),
        .rst    (rst),
        .sig_i  (sel_valid),
        .rise_o (sel_rise)
    );

    edge_rise u_cancel_edge (
        .clk    (clk),
        .rst    (rst),
        .sig_i  (cancel),
        .rise_o (cancel_rise)
    );

    // Price of the item currently presented on sel_item.
    always_comb begin
        sel_price = PRICE0;
        case (sel_item)
            2'd0: sel_price = PRICE0;
            2'd1: sel_price = PRICE1;
            2'd2: sel_price = PRICE2;
            2'd3: sel_price = PRICE3;
            default: sel_price = PRICE0;
        endcase
    end

    // State and transaction data registers; reset aborts any transaction.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            item_q   <= '0;
            price_q  <= '0;
            change_q <= '0;
            cnt_q    <= '0;
            refund_q <= 1'b0;
            insuff_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            item_q   <= item_d;
            price_q  <= price_d;
            change_q <= change_d;
            cnt_q    <= cnt_d;
            refund_q <= refund_d;
            insuff_q <= insuff_d;
        end
    end

    // Next-state logic; edges are only honoured in IDLE and otherwise dropped.
    always_comb begin
        state_d  = state_q;
        item_d   = item_q;
        price_d  = price_q;
        change_d = change_q;
        cnt_d    = cnt_q;
        refund_d = refund_q;
        insuff_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (cancel_rise) begin
                    refund_d = 1'b1;
                    state_d  = S_ARM;
                end else if (sel_rise) begin
                    item_d   = sel_item;
                    price_d  = sel_price;
                    refund_d = 1'b0;
                    state_d  = S_ARM;
                end
            end
            S_ARM: state_d = S_EVAL;
            S_EVAL: begin
                if (refund_q) begin
                    if (moneyv != '0) begin
                        change_d = moneyv;
                        cnt_d    = CHG_LOAD;
                        state_d  = S_CHANGE;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else if (moneyv >= price_q) begin
                    change_d = moneyv - price_q;
                    cnt_d    = DISP_LOAD;
                    state_d  = S_DISPENSE;
                end else begin
                    insuff_d = 1'b1;
                    state_d  = S_IDLE;
                end
            end
            S_DISPENSE: begin
                if (cnt_q == '0) begin
                    if (change_q != '0) begin
                        cnt_d   = CHG_LOAD;
                        state_d = S_CHANGE;
                    end else begin
                        state_d = S_CLEAR;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_CHANGE: begin
                if (cnt_q == '0) state_d = S_CLEAR;
                else             cnt_d   = cnt_q - CNT_W'(1);
            end
            S_CLEAR: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign lock          = (state_q != S_IDLE);
    assign macc_rst      = (state_q == S_CLEAR);
    assign dispense      = (state_q == S_DISPENSE);
    assign dispense_item = dispense ? item_q : '0;
    assign change_valid  = (state_q == S_CHANGE);
    assign change_amt    = change_valid ? change_q : '0;
    assign insufficient  = insuff_q;

endmodule

// File: tb/tb_vend_controller.sv
// Directed testbench for vend_controller with default parameters.
module tb_vend_controller;
    import vend_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] moneyv;
    logic       sel_valid;
    logic [1:0] sel_item;
    logic       cancel;
    logic       lock, macc_rst, dispense, change_valid, insufficient;
    logic [1:0] dispense_item;
    logic [7:0] change_amt;

    int passed = 0;
    int total  = 0;

    vend_controller dut (
        .clk           (clk),
        .rst           (rst),
        .moneyv        (moneyv),
        .sel_valid     (sel_valid),
        .sel_item      (sel_item),
        .cancel        (cancel),
        .lock          (lock),
        .macc_rst      (macc_rst),
        .dispense      (dispense),
        .dispense_item (dispense_item),
        .change_valid  (change_valid),
        .change_amt    (change_amt),
        .insufficient  (insufficient)
    );

    always #5 clk = ~clk;

    // Output bundle: {lock, macc_rst, dispense, item[1:0], change_valid, amt[7:0], insufficient}
    logic [14:0] obs;
    assign obs = {lock, macc_rst, dispense, dispense_item, change_valid, change_amt, insufficient};

    function automatic logic [14:0] ev(input logic l, input logic m, input logic d,
                                       input logic [1:0] it, input logic cv,
                                       input logic [7:0] amt, input logic ins);
        return {l, m, d, it, cv, amt, ins};
    endfunction

    // Presents a one-cycle select pulse; returns at the negedge after the accepting posedge.
    task automatic press_select(input logic [1:0] it);
        @(negedge clk);
        sel_item  = it;
        sel_valid = 1'b1;
        @(negedge clk);
        sel_valid = 1'b0;
    endtask

    task automatic press_cancel();
        @(negedge clk);
        cancel = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        total++;
        if (obs !== 15'd0) $display("FAIL reset_outputs got %h exp %h", obs, 15'd0);
        else passed++;
        total++;
        if (dut.state_q !== S_IDLE) $display("FAIL reset_state got %0d exp %0d", dut.state_q, S_IDLE);
        else passed++;
        rst = 1'b0;
        @(negedge clk);
    endtask

    // 20 credit, item 2 (price 10): dispense 4, change 10 for 4, clear 1.
    task automatic test_buy_change();
        logic [14:0] exp;
        moneyv = 8'd20;
        press_select(2'd2);
        for (int k = 0; k < 12; k++) begin
            if (k > 0) @(negedge clk);
            if (k < 2)       exp = ev(1, 0, 0, 2'd0, 0, 8'd0, 0);
            else if (k < 6)  exp = ev(1, 0, 1, 2'd2, 0, 8'd0, 0);
            else if (k < 10) exp = ev(1, 0, 0, 2'd0, 1, 8'd10, 0);
            else if (k == 10) exp = ev(1, 1, 0, 2'd0, 0, 8'd0, 0);
            else             exp = 15'd0;
            total++;
            if (obs !== exp) $display("FAIL buy_change k=%0d got %h exp %h", k, obs, exp);
            else passed++;
        end
    endtask

    // 4 credit, item 0 (price 5): two lock cycles, then one insufficient pulse.
    task automatic test_insufficient();
        logic [14:0] exp;
        moneyv = 8'd4;
        press_select(2'd0);
        for (int k = 0; k < 5; k++) begin
            if (k > 0) @(negedge clk);
            if (k < 2)       exp = ev(1, 0, 0, 2'd0, 0, 8'd0, 0);
            else if (k == 2) exp = ev(0, 0, 0, 2'd0, 0, 8'd0, 1);
            else             exp = 15'd0;
            total++;
            if (obs !== exp) $display("FAIL insufficient k=%0d got %h exp %h", k, obs, exp);
            else passed++;
        end
    endtask

    // 30 credit, item 3 (price 30): exact, no change phase.
    task automatic test_exact();
        logic [14:0] exp;
        moneyv = 8'd30;
        press_select(2'd3);
        for (int k = 0; k < 8; k++) begin
            if (k > 0) @(negedge clk);
            if (k < 2)       exp = ev(1, 0, 0, 2'd0, 0, 8'd0, 0);
            else if (k < 6)  exp = ev(1, 0, 1, 2'd3, 0, 8'd0, 0);
            else if (k == 6) exp = ev(1, 1, 0, 2'd0, 0, 8'd0, 0);
            else             exp = 15'd0;
            total++;
            if (obs !== exp) $display("FAIL exact k=%0d got %h exp %h", k, obs, exp);
            else passed++;
        end
    endtask

    task automatic test_refund();
        logic [14:0] exp;
        moneyv = 8'd22;
        press_cancel();
        for (int k = 0; k < 8; k++) begin
            if (k > 0) @(negedge clk);
            if (k < 2)       exp = ev(1, 0, 0, 2'd0, 0, 8'd0, 0);
            else if (k < 6)  exp = ev(1, 0, 0, 2'd0, 1, 8'd22, 0);
            else if (k == 6) exp = ev(1, 1, 0, 2'd0, 0, 8'd0, 0);
            else             exp = 15'd0;
            total++;
            if (obs !== exp) $display("FAIL refund k=%0d got %h exp %h", k, obs, exp);
            else passed++;
        end
        moneyv = 8'd0;
        press_cancel();
        for (int k = 0; k < 4; k++) begin
            if (k > 0) @(negedge clk);
            exp = (k < 2) ? ev(1, 0, 0, 2'd0, 0, 8'd0, 0) : 15'd0;
            total++;
            if (obs !== exp) $display("FAIL refund_zero k=%0d got %h exp %h", k, obs, exp);
            else passed++;
        end
    endtask

    // Cancel and select edges in one cycle: cancel wins.
    task automatic test_simultaneous();
        logic [14:0] exp;
        moneyv = 8'd10;
        @(negedge clk);
        sel_item  = 2'd1;
        sel_valid = 1'b1;
        cancel    = 1'b1;
        @(negedge clk);
        sel_valid = 1'b0;
        cancel    = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (k > 0) @(negedge clk);
            if (k < 2)       exp = ev(1, 0, 0, 2'd0, 0, 8'd0, 0);
            else if (k < 6)  exp = ev(1, 0, 0, 2'd0, 1, 8'd10, 0);
            else if (k == 6) exp = ev(1, 1, 0, 2'd0, 0, 8'd0, 0);
            else             exp = 15'd0;
            total++;
            if (obs !== exp) $display("FAIL simultaneous k=%0d got %h exp %h", k, obs, exp);
            else passed++;
        end
    endtask

    // Select pulse during DISPENSE must not start another transaction.
    task automatic test_ignore_select();
        logic [14:0] exp;
        moneyv = 8'd10;
        press_select(2'd2);
        for (int k = 0; k < 10; k++) begin
            if (k > 0) @(negedge clk);
            if (k < 2)       exp = ev(1, 0, 0, 2'd0, 0, 8'd0, 0);
            else if (k < 6)  exp = ev(1, 0, 1, 2'd2, 0, 8'd0, 0);
            else if (k == 6) exp = ev(1, 1, 0, 2'd0, 0, 8'd0, 0);
            else             exp = 15'd0;
            total++;
            if (obs !== exp) $display("FAIL ignore_select k=%0d got %h exp %h", k, obs, exp);
            else passed++;
            if (k == 3) begin
                sel_item  = 2'd0;
                sel_valid = 1'b1;
            end else begin
                sel_valid = 1'b0;
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [14:0] exp;
        moneyv = 8'd20;
        press_select(2'd1);
        @(negedge clk);
        @(negedge clk);
        total++;
        if (obs !== ev(1, 0, 1, 2'd1, 0, 8'd0, 0))
            $display("FAIL reset_mid_pre got %h exp %h", obs, ev(1, 0, 1, 2'd1, 0, 8'd0, 0));
        else passed++;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        total++;
        if (obs !== 15'd0) $display("FAIL reset_mid_outputs got %h exp %h", obs, 15'd0);
        else passed++;
        total++;
        if (dut.state_q !== S_IDLE) $display("FAIL reset_mid_state got %0d exp %0d", dut.state_q, S_IDLE);
        else passed++;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if (obs !== 15'd0) $display("FAIL reset_mid_quiet got %h exp %h", obs, 15'd0);
        else passed++;
        moneyv = 8'd6;
        press_select(2'd1);
        for (int k = 0; k < 8; k++) begin
            if (k > 0) @(negedge clk);
            if (k < 2)       exp = ev(1, 0, 0, 2'd0, 0, 8'd0, 0);
            else if (k < 6)  exp = ev(1, 0, 1, 2'd1, 0, 8'd0, 0);
            else if (k == 6) exp = ev(1, 1, 0, 2'd0, 0, 8'd0, 0);
            else             exp = 15'd0;
            total++;
            if (obs !== exp) $display("FAIL after_reset k=%0d got %h exp %h", k, obs, exp);
            else passed++;
        end
    endtask

    initial begin
        rst       = 1'b1;
        moneyv    = 8'd0;
        sel_valid = 1'b0;
        sel_item  = 2'd0;
        cancel    = 1'b0;
        test_reset();
        test_buy_change();
        test_insufficient();
        test_exact();
        test_refund();
        test_simultaneous();
        test_ignore_select();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/vend_controller.md
# vend_controller

Purchase sequencer directly downstream of the coin accumulator. It reads the accumulated credit, handles item selection and cancel requests, and freezes the accumulator while a transaction is evaluated. It then drives the dispense and change outputs and finally clears the accumulator. All money values are in the accumulator's half-unit scale: a 1-coin adds 2 and a 10-coin adds 20.

## Interface
- PRICE0, default 5: price of item 0, in half-units (8 bit).
- PRICE1, default 6: price of item 1.
- PRICE2, default 10: price of item 2.
- PRICE3, default 30: price of item 3.
- DISP_CYCLES, default 4: number of cycles `dispense` is held high (≥1).
- CHG_CYCLES, default 4: number of cycles `change_valid` is held high (≥1).
- clk  in  1  single clock; all logic is on posedge.
- rst  in  1  synchronous, active-high reset.
- moneyv  in  8  credit from the accumulator (unsigned).
- sel_valid  in  1  item-select button, level; its rising edge is the request.
- sel_item  in  2  item index, sampled on the `sel_valid` rising edge.
- cancel  in  1  refund button, level; its rising edge is the request.
- lock  out  1  freezes the accumulator; high in every state except IDLE.
- macc_rst  out  1  one-cycle clear pulse to the accumulator.
- dispense  out  1  dispense strobe, held high for DISP_CYCLES cycles.
- dispense_item  out  2  latched item index, valid while `dispense` is high.
- change_valid  out  1  high for CHG_CYCLES cycles.
- change_amt  out  8  change to return, valid while `change_valid` is high; 0 otherwise.
- insufficient  out  1  one-cycle pulse when a selection is rejected for lack of credit.

## Operation
- Rising-edge detect:
  - Registered previous value of `sel_valid` and of `cancel`.
  - Edge = current & ~previous.
  - Previous-value registers update every cycle in every state.
  - Edges are acted on only in IDLE. Edges arriving in any other state are discarded, not queued.
- States: IDLE, ARM, EVAL, DISPENSE, CHANGE, CLEAR. All outputs are Moore, decoded from registered state plus registered data.
- IDLE:
  - Cancel edge: set `is_refund`=1 and go to ARM.
  - Otherwise, select edge: latch `sel_item`, latch the matching price, set `is_refund`=0, go to ARM.
  - Cancel wins over a simultaneous select edge.
- ARM: lock high for one settling cycle, then EVAL. A coin counted on the accept edge has settled into `moneyv` by then.
- EVAL (moneyv is now frozen):
  - Refund with moneyv≠0: change = moneyv, go to CHANGE.
  - Refund with moneyv=0: go to IDLE, no pulses.
  - Select with moneyv ≥ price (unsigned 8-bit compare): change = moneyv − price (no underflow possible), go to DISPENSE.
  - Select with moneyv < price: pulse `insufficient` for the next cycle, go to IDLE. Credit is retained and there is no `macc_rst`.
- DISPENSE: hold for DISP_CYCLES cycles, then go to CHANGE if change≠0, else CLEAR.
- CHANGE: hold for CHG_CYCLES cycles, then CLEAR.
- CLEAR: `macc_rst` high for exactly 1 cycle (lock also high), then IDLE.
- `rst`:
  - Forces IDLE and clears all outputs, counters, latches and edge registers to 0.
  - This applies mid-transaction too: the transaction aborts with no further dispense or change.

## Timing
- Select edge sampled at posedge N:
  - ARM during N..N+1, EVAL during N+1..N+2.
  - `dispense` is high from after N+2 for DISP_CYCLES cycles.
- `lock` rises in the cycle after the accepting edge. The accumulator may still add at edge N; that credit is counted in EVAL.
- Minimum IDLE-to-IDLE transaction (exact price, no change) = 3 + DISP_CYCLES cycles.
- Reset values: lock=0, macc_rst=0, dispense=0, dispense_item=0, change_valid=0, change_amt=0, insufficient=0.
- Hold counters are sized to max(DISP_CYCLES, CHG_CYCLES) and reload on state entry.

## Structure
- Shared package `vend_pkg`:
  - state enum;
  - item-index width;
  - default price constants;
  - money width (8).
- One sub-module, `edge_rise`: registered rising-edge detector with synchronous active-high reset. Instantiated twice, for select and cancel.

## Test plan
- moneyv=20, select item 2 (price 10) → `dispense`=1 with item=2 for 4 cycles; `change_valid` with change_amt=10 for 4 cycles; `macc_rst` for 1 cycle; lock high throughout, then 0.
- moneyv=4, select item 0 (price 5) → `insufficient` pulses for 1 cycle, no dispense, no `macc_rst`; lock high for 2 cycles, then IDLE.
- moneyv=30, select item 3 → dispense for 4 cycles, no change phase, `macc_rst` on the next cycle.
- moneyv=22, cancel → change_amt=22 for 4 cycles, then `macc_rst`. Cancel with moneyv=0 → no pulses, lock high for 2 cycles only.
- Select and cancel edges in the same cycle with moneyv=10 → refund of 10, no dispense. Extra select pulses during DISPENSE are ignored.
- `rst` asserted in the 2nd DISPENSE cycle → next cycle all outputs are 0 and the state is IDLE. A select after reset is processed normally.
